// File: rtl/serial_sub4.sv
// Bit-serial subtractor d = a - b - bin, LSB first, one full-subtractor cell plus a borrow flop.
// Optional signed-overflow output enabled by defining SERIAL_SUB4_OVF_EN.
module serial_sub4 #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
`ifdef SERIAL_SUB4_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   sa, sb, res, res_next;
  logic               br, br_next, x;
  logic [CNT_W-1:0]   cnt;
  logic               accept, last;
`ifdef SERIAL_SUB4_OVF_EN
  logic               am, bm;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        // A start here is taken immediately so ops can run back to back.
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    x        = sa[0] ^ sb[0] ^ br;
    br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    res_next = {x, res[WIDTH-1:1]};
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa  <= '0;
      sb  <= '0;
      br  <= 1'b0;
      res <= '0;
      cnt <= '0;
      d   <= '0;
      bo  <= 1'b0;
`ifdef SERIAL_SUB4_OVF_EN
      am  <= 1'b0;
      bm  <= 1'b0;
      ovf <= 1'b0;
`endif
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      br  <= bin;
      res <= '0;
      cnt <= '0;
`ifdef SERIAL_SUB4_OVF_EN
      am  <= a[WIDTH-1];
      bm  <= b[WIDTH-1];
`endif
    end else if (state == SHIFT) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      br  <= br_next;
      res <= res_next;
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        d   <= res_next;
        bo  <= br_next;
`ifdef SERIAL_SUB4_OVF_EN
        // x is the result MSB on the final step.
        ovf <= (am != bm) && (x != am);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_sub4.sv
// Self-checking bench for serial_sub4: directed table, hand-written corner sequences,
// and random operands checked against an integer-arithmetic reference model.
module tb_serial_sub4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n, start, bin;
  logic [W-1:0] a, b, d;
  logic         busy, done, bo;
`ifdef SERIAL_SUB4_OVF_EN
  logic         ovf;
`endif

  int vectors     = 0;
  int miscompares = 0;

  serial_sub4 #(.WIDTH(W), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bo    (bo)
`ifdef SERIAL_SUB4_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ovf;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer subtraction; returns {ovf, bo, d}.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mbin);
    int diff;
    logic [W-1:0] md;
    logic mbo, movf;
    diff = int'(ma) - int'(mb) - int'(mbin);
    md   = diff[W-1:0];
    mbo  = (int'(ma) < int'(mb) + int'(mbin));
    movf = (ma[W-1] != mb[W-1]) && (md[W-1] != ma[W-1]);
    return {movf, mbo, md};
  endfunction

  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tbin, input logic [W-1:0] ed, input logic ebo,
                        input logic eovf);
    int lat, busy_cyc;
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    lat = 1;
    busy_cyc = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
    chk({name, ".latency"}, lat, 5);
    chk({name, ".busy_cycles"}, busy_cyc, 4);
    chk({name, ".d"}, d, ed);
    chk({name, ".bo"}, bo, ebo);
`ifdef SERIAL_SUB4_OVF_EN
    chk({name, ".ovf"}, ovf, eovf);
`else
    if (eovf === 1'bx) $display("note: unexpected X in ovf expectation");
`endif
    @(negedge clk);
    chk({name, ".done_one_cycle"}, done, 0);
    chk({name, ".d_hold"}, d, ed);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W+1:0] r;
    logic [W-1:0] ra, rb;
    logic         rbin;
    int           pulses;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    tbl[0] = '{4'b0001, 4'b0011, 1'b0, 4'b1110, 1'b1, 1'b0};
    tbl[1] = '{4'b1101, 4'b0011, 1'b1, 4'b1001, 1'b0, 1'b0};
    tbl[2] = '{4'b0011, 4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[3] = '{4'b1111, 4'b1101, 1'b1, 4'b0001, 1'b0, 1'b0};
    tbl[4] = '{4'b1001, 4'b0011, 1'b1, 4'b0101, 1'b0, 1'b1};
    tbl[5] = '{4'b0101, 4'b1011, 1'b0, 4'b1010, 1'b1, 1'b1};
    tbl[6] = '{4'b0001, 4'b1011, 1'b0, 4'b0110, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.d", d, 0);
    chk("reset.bo", bo, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].bin,
             tbl[i].d, tbl[i].bo, tbl[i].ovf);

    // Back-to-back: start held through DONE; operand changes while busy are ignored.
    @(negedge clk);
    a = 4'b0001; b = 4'b0011; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 4'b1111; b = 4'b1101; bin = 1'b1;
    repeat (3) @(negedge clk);
    chk("b2b.busy_before_done", busy, 1);
    chk("b2b.no_early_done", done, 0);
    @(negedge clk);
    chk("b2b.first_done", done, 1);
    chk("b2b.first_d", d, 4'b1110);
    chk("b2b.first_bo", bo, 1);
    @(negedge clk);
    start = 1'b0;
    chk("b2b.accepted_in_done", busy, 1);
    a = W'($urandom); b = W'($urandom);
    repeat (3) @(negedge clk);
    chk("b2b.second_not_early", done, 0);
    @(negedge clk);
    chk("b2b.second_done", done, 1);
    chk("b2b.second_d", d, 4'b0001);
    chk("b2b.second_bo", bo, 0);
    @(negedge clk);
    chk("b2b.idle_after", busy, 0);

    // Start pulse while busy must be ignored.
    @(negedge clk);
    a = 4'b1001; b = 4'b0011; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'b0000; b = 4'b1111; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("ignore.done", done, 1);
    chk("ignore.d", d, 4'b0101);
    chk("ignore.bo", bo, 0);
    @(negedge clk);
    chk("ignore.no_second_op", busy, 0);
    chk("ignore.no_second_done", done, 0);

    // Asynchronous reset two cycles into a shift.
    @(negedge clk);
    a = 4'b1101; b = 4'b0011; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.done", done, 0);
    chk("midrst.d", d, 0);
    chk("midrst.bo", bo, 0);
`ifdef SERIAL_SUB4_OVF_EN
    chk("midrst.ovf", ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    chk("midrst.no_done_after", pulses, 0);
    run_op("recover", tbl[1].a, tbl[1].b, tbl[1].bin, tbl[1].d, tbl[1].bo, tbl[1].ovf);

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      r = model(ra, rb, rbin);
      run_op($sformatf("rand%0d", i), ra, rb, rbin, r[W-1:0], r[W], r[W+1]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
